// File: rtl/commit_pkg.sv
// Shared types and defaults for the in-order commit buffer.
//   rob_entry_t     : per-entry status flags (valid, done, wen)
//   c_default_depth : default number of buffer entries
// Physical register widths stay module parameters so the rename table
// and this block can be sized together at instantiation.
package commit_pkg;

  localparam int unsigned c_default_depth         = 16;
  localparam int unsigned c_default_num_phys_regs = 36;

  typedef struct packed {
    logic valid;  // entry holds an in-flight instruction
    logic done;   // execute has reported writeback
    logic wen;    // instruction writes a destination register
  } rob_entry_t;

endpackage

// File: rtl/commit_rob_if.sv
// CompleteNotif: retirement notification from the commit buffer to the
// rename table.
//   val   : one instruction with a destination register retired this cycle
//   preg  : its physical destination register (clear pending bit)
//   ppreg : the previous mapping of that architectural register (free it)
// Modports: pub (publisher, drives) and sub (subscriber, observes).
interface complete_notif #(
  parameter int p_phys_addr_bits = 6
);

  logic                        val;
  logic [p_phys_addr_bits-1:0] preg;
  logic [p_phys_addr_bits-1:0] ppreg;

  modport pub (output val, preg, ppreg);
  modport sub (input  val, preg, ppreg);

endinterface

// File: rtl/commit_rob_wrap_ptr.sv
// rob_wrap_ptr: circular-buffer pointer with an extra wrap bit.
//   clk, rst : clock; synchronous active-low reset (ptr -> 0)
//   inc      : advance the pointer by one entry
//   ptr      : {wrap, index}; the buffer depth is 2**p_idx_bits, so the
//              plain binary increment wraps the index and toggles the wrap
//              bit in one step.
module rob_wrap_ptr #(
  parameter int p_idx_bits = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  output logic [p_idx_bits:0] ptr
);

  // NOTE: sequential state is always assigned with <=, so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/commit_rob.sv
// commit_rob: in-order completion buffer.
// Decode/issue allocates one entry per renamed instruction in program
// order; execute marks entries done out of order by sequence number; the
// head entry retires once done, at most one per cycle, and publishes its
// preg/ppreg on the CompleteNotif interface when it writes a register.
//
// Ports:
//   clk, rst      : clock; synchronous active-low reset (discards all
//                   in-flight entries without notification)
//   alloc_en      : allocate request
//   alloc_rdy     : an entry is free (depends on full only)
//   alloc_wen     : allocated instruction writes a destination
//   alloc_preg    : newly allocated physical register
//   alloc_ppreg   : previous physical register, freed at commit
//   alloc_seq_num : index assigned to this allocation (current tail)
//   wb_val        : writeback strobe
//   wb_seq_num    : entry that finished
//   complete      : CompleteNotif publisher (val, preg, ppreg)
//
// Build option COMMIT_ROB_WB_BYPASS_EN: a writeback hitting the valid
// head entry retires it in the same cycle (0-cycle wb-to-complete
// latency). Without it, done is registered first (1-cycle latency).
module commit_rob
  import commit_pkg::*;
#(
  parameter int p_depth          = c_default_depth,
  parameter int p_num_phys_regs  = c_default_num_phys_regs,
  parameter int p_phys_addr_bits = $clog2(p_num_phys_regs),
  parameter int p_seq_num_bits   = $clog2(p_depth)
) (
  input  logic                        clk,
  input  logic                        rst,

  input  logic                        alloc_en,
  output logic                        alloc_rdy,
  input  logic                        alloc_wen,
  input  logic [p_phys_addr_bits-1:0] alloc_preg,
  input  logic [p_phys_addr_bits-1:0] alloc_ppreg,
  output logic [p_seq_num_bits-1:0]   alloc_seq_num,

  input  logic                        wb_val,
  input  logic [p_seq_num_bits-1:0]   wb_seq_num,

  complete_notif.pub                  complete
);

  rob_entry_t                  rob_q     [p_depth];
  logic [p_phys_addr_bits-1:0] preg_q    [p_depth];
  logic [p_phys_addr_bits-1:0] ppreg_q   [p_depth];

  logic [p_seq_num_bits:0]     head_ptr;
  logic [p_seq_num_bits:0]     tail_ptr;
  logic [p_seq_num_bits-1:0]   head_idx;
  logic [p_seq_num_bits-1:0]   tail_idx;
  rob_entry_t                  head_entry;

  logic                        full;
  logic                        alloc_xfer;
  logic                        head_done;
  logic                        commit;

  assign head_idx   = head_ptr[p_seq_num_bits-1:0];
  assign tail_idx   = tail_ptr[p_seq_num_bits-1:0];
  assign head_entry = rob_q[head_idx];

  // Same index with opposite wrap bits means the tail has lapped the head.
  assign full = (head_idx == tail_idx) &&
                (head_ptr[p_seq_num_bits] != tail_ptr[p_seq_num_bits]);

  // Ready looks only at registered occupancy, so a same-cycle commit never
  // creates a combinational path from writeback into allocation.
  assign alloc_rdy     = !full;
  assign alloc_seq_num = tail_idx;
  assign alloc_xfer    = alloc_en && alloc_rdy;

`ifdef COMMIT_ROB_WB_BYPASS_EN
  // A writeback aimed at the valid head counts as done this cycle.
  assign head_done = head_entry.done ||
                     (wb_val && (wb_seq_num == head_idx));
`else
  assign head_done = head_entry.done;
`endif

  assign commit = head_entry.valid && head_done;

  // NOTE: every output of this block is assigned a default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    complete.val   = 1'b0;
    complete.preg  = '0;
    complete.ppreg = '0;
    if (commit && head_entry.wen) begin
      complete.val   = 1'b1;
      complete.preg  = preg_q[head_idx];
      complete.ppreg = ppreg_q[head_idx];
    end
  end

  rob_wrap_ptr #(.p_idx_bits(p_seq_num_bits)) u_head_ptr (
    .clk (clk),
    .rst (rst),
    .inc (commit),
    .ptr (head_ptr)
  );

  rob_wrap_ptr #(.p_idx_bits(p_seq_num_bits)) u_tail_ptr (
    .clk (clk),
    .rst (rst),
    .inc (alloc_xfer),
    .ptr (tail_ptr)
  );

  // Status flags. Allocation only targets a free slot (never the head
  // while it is committing), and a writeback to a free slot is dropped,
  // so the three updates below never compete for one live entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < p_depth; i++) begin
        rob_q[i] <= '0;
      end
    end else begin
      if (wb_val && rob_q[wb_seq_num].valid) begin
        rob_q[wb_seq_num].done <= 1'b1;
      end
      if (commit) begin
        rob_q[head_idx].valid <= 1'b0;
      end
      if (alloc_xfer) begin
        rob_q[tail_idx] <= '{valid: 1'b1, done: 1'b0, wen: alloc_wen};
      end
    end
  end

  // NOTE: the register payload arrays are not reset; they are only read
  // behind a set valid bit, and leaving them out keeps them plain RAM.
  always_ff @(posedge clk) begin
    if (alloc_xfer) begin
      preg_q[tail_idx]  <= alloc_preg;
      ppreg_q[tail_idx] <= alloc_ppreg;
    end
  end

endmodule

// File: tb/tb_commit_rob.sv
// Directed self-checking bench for commit_rob (depth 16, 36 pregs).
// Inputs change 1 ns after the rising edge; outputs are sampled in the
// same window, before the next edge. Expectations follow the bypass build
// when COMMIT_ROB_WB_BYPASS_EN is defined.
module tb_commit_rob;

  localparam int c_pa = 6;
  localparam int c_sn = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            alloc_en;
  logic            alloc_rdy;
  logic            alloc_wen;
  logic [c_pa-1:0] alloc_preg;
  logic [c_pa-1:0] alloc_ppreg;
  logic [c_sn-1:0] alloc_seq_num;
  logic            wb_val;
  logic [c_sn-1:0] wb_seq_num;

  complete_notif #(.p_phys_addr_bits(c_pa)) complete ();

  commit_rob dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_en      (alloc_en),
    .alloc_rdy     (alloc_rdy),
    .alloc_wen     (alloc_wen),
    .alloc_preg    (alloc_preg),
    .alloc_ppreg   (alloc_ppreg),
    .alloc_seq_num (alloc_seq_num),
    .wb_val        (wb_val),
    .wb_seq_num    (wb_seq_num),
    .complete      (complete)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef COMMIT_ROB_WB_BYPASS_EN
  localparam bit c_bypass = 1'b1;
`else
  localparam bit c_bypass = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_en    = 1'b0;
    alloc_wen   = 1'b0;
    alloc_preg  = '0;
    alloc_ppreg = '0;
    wb_val      = 1'b0;
    wb_seq_num  = '0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // Drives one allocation for the current cycle and checks the index.
  task automatic alloc(input logic wen, input int preg, input int ppreg,
                       input int exp_seq, input string tag);
    idle_inputs();
    alloc_en    = 1'b1;
    alloc_wen   = wen;
    alloc_preg  = c_pa'(preg);
    alloc_ppreg = c_pa'(ppreg);
    check({tag, "_rdy"}, 32'(alloc_rdy), 32'd1);
    check({tag, "_seq"}, 32'(alloc_seq_num), 32'(exp_seq));
    tick();
  endtask

  task automatic expect_complete(input logic val, input int preg,
                                 input int ppreg, input string tag);
    check({tag, "_val"},   32'(complete.val),   32'(val));
    check({tag, "_preg"},  32'(complete.preg),  32'(preg));
    check({tag, "_ppreg"}, 32'(complete.ppreg), 32'(ppreg));
  endtask

  int got_q[$];
  int exp_q[$];

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1;

    // Reset, then five idle cycles.
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      check("idle_rdy", 32'(alloc_rdy), 32'd1);
      check("idle_seq", 32'(alloc_seq_num), 32'd0);
      check("idle_val", 32'(complete.val), 32'd0);
      tick();
    end

    // Single instruction: alloc at cycle 1, wb at cycle 3.
    reset_dut();
    alloc(1'b1, 32, 5, 0, "single_alloc");
    idle_inputs();
    expect_complete(1'b0, 0, 0, "single_c2");
    tick();
    wb_val = 1'b1; wb_seq_num = 4'd0;
    if (c_bypass) expect_complete(1'b1, 32, 5, "single_c3");
    else          expect_complete(1'b0, 0, 0, "single_c3");
    tick();
    idle_inputs();
    if (c_bypass) expect_complete(1'b0, 0, 0, "single_c4");
    else          expect_complete(1'b1, 32, 5, "single_c4");
    tick();
    expect_complete(1'b0, 0, 0, "single_c5");

    // Out-of-order writebacks 2,1,0 retire in order 0,1,2.
    reset_dut();
    for (int i = 0; i < 3; i++) alloc(1'b1, 10 + i, 1 + i, i, "ooo_alloc");
    idle_inputs();
    wb_val = 1'b1; wb_seq_num = 4'd2;
    expect_complete(1'b0, 0, 0, "ooo_wb2");
    tick();
    wb_seq_num = 4'd1;
    expect_complete(1'b0, 0, 0, "ooo_wb1");
    tick();
    wb_seq_num = 4'd0;
    if (c_bypass) expect_complete(1'b1, 10, 1, "ooo_wb0");
    else          expect_complete(1'b0, 0, 0, "ooo_wb0");
    tick();
    idle_inputs();
    for (int k = (c_bypass ? 1 : 0); k < 3; k++) begin
      expect_complete(1'b1, 10 + k, 1 + k, "ooo_commit");
      tick();
    end
    expect_complete(1'b0, 0, 0, "ooo_after");

    // Fill all 16 entries, then free one while alloc_en stays high.
    reset_dut();
    for (int i = 0; i < 16; i++) alloc(1'b1, i, i + 16, i, "fill");
    alloc_en = 1'b1; alloc_wen = 1'b1;
    alloc_preg = 6'd20; alloc_ppreg = 6'd30;
    check("full_rdy", 32'(alloc_rdy), 32'd0);
    wb_val = 1'b1; wb_seq_num = 4'd0;
    if (c_bypass) begin
      expect_complete(1'b1, 0, 16, "full_commit");
      tick();
      wb_val = 1'b0;
    end else begin
      tick();
      wb_val = 1'b0;
      expect_complete(1'b1, 0, 16, "full_commit");
      check("full_rdy_commit", 32'(alloc_rdy), 32'd0);
      tick();
    end
    check("wrap_rdy", 32'(alloc_rdy), 32'd1);
    check("wrap_seq", 32'(alloc_seq_num), 32'd0);
    tick();
    // Tail {1,1} vs head {0,1}: full again, so the wrap bit is tracked.
    check("refull_rdy", 32'(alloc_rdy), 32'd0);
    idle_inputs();
    for (int s = 1; s < 16; s++) exp_q.push_back(s);
    exp_q.push_back(20);
    for (int j = 0; j < 18; j++) begin
      if (j < 16) begin
        wb_val = 1'b1;
        wb_seq_num = c_sn'((j + 1) % 16);
      end else begin
        wb_val = 1'b0;
      end
      if (complete.val) got_q.push_back(int'(complete.preg));
      tick();
    end
    check("drain_count", 32'(got_q.size()), 32'd16);
    for (int j = 0; j < 16 && j < got_q.size(); j++) begin
      check("drain_order", 32'(got_q[j]), 32'(exp_q[j]));
    end
    check("drain_rdy", 32'(alloc_rdy), 32'd1);
    check("drain_seq", 32'(alloc_seq_num), 32'd1);

    // Instruction without a destination retires silently.
    reset_dut();
    alloc(1'b0, 7, 9, 0, "nowen_alloc");
    idle_inputs();
    wb_val = 1'b1; wb_seq_num = 4'd0;
    expect_complete(1'b0, 0, 0, "nowen_wb");
    tick();
    idle_inputs();
    expect_complete(1'b0, 0, 0, "nowen_after");
    alloc(1'b1, 3, 4, 1, "nowen_next");
    idle_inputs();
    wb_val = 1'b1; wb_seq_num = 4'd1;
    if (c_bypass) expect_complete(1'b1, 3, 4, "nowen_next_c");
    tick();
    idle_inputs();
    if (!c_bypass) expect_complete(1'b1, 3, 4, "nowen_next_c");

    // Mid-flight reset discards four entries, two of them done.
    reset_dut();
    for (int i = 0; i < 4; i++) alloc(1'b1, 20 + i, i, i, "flush_alloc");
    idle_inputs();
    wb_val = 1'b1; wb_seq_num = 4'd2;
    tick();
    wb_seq_num = 4'd3;
    tick();
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      if (i == 1) begin
        wb_val = 1'b1; wb_seq_num = 4'd0;  // targets a discarded entry
      end else begin
        wb_val = 1'b0;
      end
      check("flush_val", 32'(complete.val), 32'd0);
      tick();
    end
    check("flush_rdy", 32'(alloc_rdy), 32'd1);
    check("flush_seq", 32'(alloc_seq_num), 32'd0);
    alloc(1'b1, 33, 2, 0, "flush_realloc");
    idle_inputs();
    check("flush_seq_next", 32'(alloc_seq_num), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
